// File: rtl/division_arbiter_2_if.sv
// Requester-side and divider-side signals of the two-port division arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface division_arbiter_2_if;
  logic        req0;
  logic        req1;
  logic [31:0] op1_0;
  logic [31:0] op2_0;
  logic [31:0] op1_1;
  logic [31:0] op2_1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [63:0] result;
  logic        div_zero;
  logic        timeout_err;
  logic        div_start;
  logic [31:0] div_operand1;
  logic [31:0] div_operand2;
  logic [63:0] div_result;
  logic        div_finish;

  modport slave (
    input  req0, req1, op1_0, op2_0, op1_1, op2_1, div_result, div_finish,
    output gnt0, gnt1, done0, done1, result, div_zero, timeout_err,
           div_start, div_operand1, div_operand2
  );

  modport master (
    output req0, req1, op1_0, op2_0, op1_1, op2_1, div_result, div_finish,
    input  gnt0, gnt1, done0, done1, result, div_zero, timeout_err,
           div_start, div_operand1, div_operand2
  );
endinterface

// File: rtl/division_arbiter_2.sv
// Round-robin arbiter sharing one 32-bit signed divider between two requesters,
// with divide-by-zero bypass and a watchdog on the divider's completion.
module division_arbiter_2 #(
  parameter int TIMEOUT = 40
) (
  input  logic                 clock,
  input  logic                 reset,
  division_arbiter_2_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] TIMEOUT_CNT = 6'(TIMEOUT);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [63:0] result_q, result_d;
  logic        div_zero_q, div_zero_d;
  logic        timeout_err_q, timeout_err_d;
  logic [5:0]  cnt_q, cnt_d;

  logic        any_req;
  logic        winner;
  logic [31:0] win_a;
  logic [31:0] win_b;
  logic [5:0]  cnt_inc;

  // last_q doubles as the owner of the in-flight operation.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      winner = ~last_q;
    end else begin
      winner = bus.req1;
    end
    win_a   = winner ? bus.op1_1 : bus.op1_0;
    win_b   = winner ? bus.op2_1 : bus.op2_0;
    cnt_inc = (cnt_q == 6'h3F) ? cnt_q : cnt_q + 6'd1;
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    result_d      = result_q;
    div_zero_d    = div_zero_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          last_d = winner;
          opa_d  = win_a;
          opb_d  = win_b;
          if (win_b == 32'd0) begin
            result_d      = 64'd0;
            div_zero_d    = 1'b1;
            timeout_err_d = 1'b0;
            state_d       = DONE;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        cnt_d   = 6'd0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A zero count marks the first WAIT cycle, where a stale finish is ignored.
        if (bus.div_finish && (cnt_q != 6'd0)) begin
          result_d      = bus.div_result;
          div_zero_d    = 1'b0;
          timeout_err_d = 1'b0;
          state_d       = DONE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          result_d      = 64'd0;
          div_zero_d    = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      opa_q         <= 32'd0;
      opb_q         <= 32'd0;
      result_q      <= 64'd0;
      div_zero_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= 6'd0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      result_q      <= result_d;
      div_zero_q    <= div_zero_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  // Grants are gated by reset so no pulse escapes while the block is held in reset.
  assign bus.gnt0         = (state_q == IDLE) && !reset && any_req && !winner;
  assign bus.gnt1         = (state_q == IDLE) && !reset && any_req && winner;
  assign bus.done0        = (state_q == DONE) && !last_q;
  assign bus.done1        = (state_q == DONE) && last_q;
  assign bus.div_start    = (state_q == START);
  assign bus.div_operand1 = opa_q;
  assign bus.div_operand2 = opb_q;
  assign bus.result       = result_q;
  assign bus.div_zero     = div_zero_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: doc/division_arbiter_2.md
DIVISION_ARBITER_2 -- requirements
Module: division_arbiter_2

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clock and reset.
REQ-002 The block SHALL have parameter TIMEOUT, default 40, the maximum WAIT cycles allowed before the divider is abandoned.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  async active-high reset.
REQ-005 req0, req1  input  1 each  level request from requester 0/1.
REQ-006 op1_0, op2_0, op1_1, op2_1  input  32 each  signed dividend/divisor per requester, sampled only at grant.
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse: operands latched, requester may change them or drop req.
REQ-008 done0, done1  output  1 each  one-cycle pulse: result/status valid for that requester.
REQ-009 result  output  64  shared result, [31:0] quotient, [63:32] remainder, valid while a done pulse is high.
REQ-010 div_zero  output  1  valid with done: divisor was 0.
REQ-011 timeout_err  output  1  valid with done: divider did not finish within TIMEOUT.
REQ-012 div_start  output  1  start pulse to the 32-bit signed divider.
REQ-013 div_operand1, div_operand2  output  32 each  divider operands.
REQ-014 div_result  input  64  divider result; div_finish  input  1  divider completion.

Function
REQ-015 The FSM SHALL have states IDLE, START, WAIT and DONE, encoded in 2 bits.
REQ-016 IDLE: with any req high, at the edge the arbiter SHALL pick a winner, latch its operands into div_operand1/2, pulse gnt, and go to START (divisor≠0) or DONE (divisor=0).
REQ-017 Arbitration SHALL be round-robin: with both req high, the winner SHALL be the requester not served last; the last-served pointer SHALL update only on grant and reset to 1, so requester 0 wins first.
REQ-018 START: div_start SHALL be 1 for exactly this one cycle; next state SHALL be WAIT and the wait counter SHALL clear.
REQ-019 div_operand1/2 SHALL stay constant from grant until the DONE cycle ends, because the divider reads the operand signs at completion.
REQ-020 WAIT: the block SHALL ignore div_finish during the first WAIT cycle, which masks a stale finish.
REQ-021 WAIT: from the second WAIT cycle, div_finish=1 SHALL register div_result into result and move to DONE.
REQ-022 WAIT: the counter SHALL increment every cycle (6 bits, saturating); at count == TIMEOUT without finish, result SHALL become 0, timeout_err=1, and the state SHALL move to DONE.
REQ-023 DONE: the done bit of the granted requester SHALL be 1 for exactly one cycle, the other done SHALL be 0, and the next state SHALL be IDLE.
REQ-024 Divide by zero SHALL bypass the divider: no div_start, result=64'h0, div_zero=1, done one cycle after gnt.
REQ-025 div_zero and timeout_err SHALL be 0 on a normal completion and SHALL hold until the next done.
REQ-026 Requests arriving outside IDLE SHALL queue (level-held) and be arbitrated on return to IDLE; no request SHALL be lost or served twice per grant.
REQ-027 Throughput SHALL be one operation per (3 + WAIT cycles); the controller SHALL NOT overlap operations.
REQ-028 gnt0/gnt1, done0/done1 and div_start SHALL be mutually exclusive within each pair and never X after reset.

Reset
REQ-029 Reset SHALL force state IDLE, all pulses 0, result=0, div_zero=0, timeout_err=0, operands=0, counter=0, and last-served=1.
REQ-030 Reset asserted mid-operation SHALL abort without any done pulse; the in-flight request is dropped, and the requester re-requests if req is still high.

Verification
REQ-031 req0 only, op1_0=100, op2_0=7 -> gnt0, then one div_start, then done0 with result[31:0]=14, [63:32]=2, flags 0.
REQ-032 req1 only, op1_1=-100, op2_1=7 -> done1 with quotient 32'hFFFFFFF2 (-14) and remainder 32'hFFFFFFFE (-2).
REQ-033 req0 and req1 held high together after reset -> grant order 0,1,0,1; done pulses alternate; no starvation.
REQ-034 req0 with op2_0=0 -> gnt0, done0 next cycle, div_zero=1, result=0, div_start never asserted.
REQ-035 div_finish tied to 0 -> done with timeout_err=1 and result=0 exactly TIMEOUT WAIT cycles after START; the next request is served normally.
REQ-036 reset pulsed during WAIT -> all outputs at reset values immediately; no done; a held req is re-granted after reset releases.
